// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: PLL reset / lock-qualification sequencer in the refclk
// domain. Pulses the PLL rst, waits for locked with a timeout, requires a
// stable lock window, then releases a synchronised active-low reset.
// Optional feature macro: PLL_RETRY_LIMIT_EN (bounded retries + sticky FAIL).
module pll_lock_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic             pll_fail
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

  if (RST_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_param
    $error("pll_lock_reset_seq: RST_CYCLES and MAX_RETRIES must be >= 1");
  end

`ifdef PLL_RETRY_LIMIT_EN
  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  logic [RW-1:0] retry_cnt;
`else
  typedef enum logic [1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lk_meta, lk_s;
  logic          tmo_evt, loss_evt;

  // Two-flop synchroniser for the asynchronous PLL locked output
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // State register and shared cycle counter
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET_PLL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode; lock has priority over timeout on the same cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    tmo_evt   = 1'b0;
    loss_evt  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TMO_LAST) begin
          tmo_evt   = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
          state_nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RESET_PLL;
`else
          state_nxt = S_RESET_PLL;
`endif
        end
      end
      S_STABLE: begin
        if (!lk_s)                 state_nxt = S_WAIT_LOCK;
        else if (cnt == STB_LAST)  state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt;
        if (!lk_s) begin
          loss_evt  = 1'b1;
          state_nxt = S_RESET_PLL;
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      S_FAIL: begin
        cnt_nxt = cnt;
      end
`endif
      default: state_nxt = S_RESET_PLL;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Saturating timeout / lock-loss event counters; only rst_n clears them
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
      loss_cnt    <= '0;
    end else begin
      if (tmo_evt && (timeout_cnt != '1))  timeout_cnt <= timeout_cnt + 1'b1;
      if (loss_evt && (loss_cnt != '1))    loss_cnt    <= loss_cnt + 1'b1;
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  // Per-sequence retry count: bumps on each timeout, cleared on entry to RUN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (tmo_evt) begin
      retry_cnt <= retry_cnt + 1'b1;
    end else if (state_nxt == S_RUN && state != S_RUN) begin
      retry_cnt <= '0;
    end
  end
  assign pll_fail = (state == S_FAIL);
  assign pll_rst  = (state == S_RESET_PLL) || (state == S_FAIL);
`else
  assign pll_fail = 1'b0;
  assign pll_rst  = (state == S_RESET_PLL);
`endif

  // Release flop: registered from next-state so it tracks RUN cycle-exactly
  // (high on the first RUN cycle, low on the first RESET_PLL cycle)
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sys_rst_n <= 1'b0;
    else        sys_rst_n <= (state_nxt == S_RUN);
  end

  assign ready = (state == S_RUN);

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: scoreboard bench for pll_lock_reset_seq. Expected
// values are queued with the cycle they apply to and checked on the falling
// edge. Cycle 0 is the first cycle after rst_n release.
module tb_pll_lock_reset_seq;

  localparam int CNT_W = 8;

  logic             refclk;
  logic             rst_n;
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic             pll_fail;

  pll_lock_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .timeout_cnt(timeout_cnt),
    .loss_cnt   (loss_cnt),
    .pll_fail   (pll_fail)
  );

  typedef enum int {SG_PLL_RST, SG_SYS_RST_N, SG_READY, SG_TCNT, SG_LCNT, SG_FAIL} sig_e;
  typedef struct {
    int          at;
    sig_e        sig;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t ent;
  int        cyc;
  int        tests;
  int        errors;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SG_PLL_RST:   return {31'b0, pll_rst};
      SG_SYS_RST_N: return {31'b0, sys_rst_n};
      SG_READY:     return {31'b0, ready};
      SG_TCNT:      return 32'(timeout_cnt);
      SG_LCNT:      return 32'(loss_cnt);
      SG_FAIL:      return {31'b0, pll_fail};
      default:      return '1;
    endcase
  endfunction

  function automatic string sig_name(input sig_e s);
    case (s)
      SG_PLL_RST:   return "pll_rst";
      SG_SYS_RST_N: return "sys_rst_n";
      SG_READY:     return "ready";
      SG_TCNT:      return "timeout_cnt";
      SG_LCNT:      return "loss_cnt";
      SG_FAIL:      return "pll_fail";
      default:      return "unknown";
    endcase
  endfunction

  // Queue an expectation; callers push in non-decreasing cycle order
  task automatic expect_at(input int at, input sig_e s, input logic [31:0] v);
    sb_entry_t e;
    e.at  = at;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Pop and compare every expectation due in the current cycle
  always @(negedge refclk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      ent = sb.pop_front();
      if (ent.at != cyc)
        check_eq("sb_order", 32'(cyc), 32'(ent.at));
      else
        check_eq($sformatf("%s@%0d", sig_name(ent.sig), ent.at), sample(ent.sig), ent.exp);
    end
  end

  task automatic tick();
    @(posedge refclk);
    cyc++;
    #1;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic finish_scn(input int last);
    run_until(last);
    @(negedge refclk);
    #1;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_rst"},   {31'b0, pll_rst},   32'd1);
    check_eq({tag, "_sys_rst_n"}, {31'b0, sys_rst_n}, 32'd0);
    check_eq({tag, "_ready"},     {31'b0, ready},     32'd0);
    check_eq({tag, "_tcnt"},      32'(timeout_cnt),   32'd0);
    check_eq({tag, "_lcnt"},      32'(loss_cnt),      32'd0);
    check_eq({tag, "_fail"},      {31'b0, pll_fail},  32'd0);
  endtask

  task automatic release_reset();
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Assert rst_n between edges and check outputs before the next edge
  task automatic apply_reset(input string tag);
    @(posedge refclk);
    #2;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(posedge refclk);
    release_reset();
  endtask

  initial begin
    tests      = 0;
    errors     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #12;
    check_reset_vals("por");
    release_reset();

    // Clean bring-up: lock at cycle 10, release at 10+2+8+1
    expect_at(0,  SG_PLL_RST,   1);
    expect_at(0,  SG_SYS_RST_N, 0);
    expect_at(0,  SG_READY,     0);
    expect_at(3,  SG_PLL_RST,   1);
    expect_at(4,  SG_PLL_RST,   0);
    expect_at(20, SG_SYS_RST_N, 0);
    expect_at(20, SG_READY,     0);
    expect_at(21, SG_SYS_RST_N, 1);
    expect_at(21, SG_READY,     1);
    expect_at(21, SG_PLL_RST,   0);
    expect_at(21, SG_TCNT,      0);
    expect_at(21, SG_LCNT,      0);
    expect_at(21, SG_FAIL,      0);
    run_until(10);
    pll_locked = 1'b1;
    finish_scn(21);

    // Lock loss in RUN at cycle 25, relock at cycle 30
    expect_at(27, SG_SYS_RST_N, 1);
    expect_at(27, SG_PLL_RST,   0);
    expect_at(27, SG_LCNT,      0);
    expect_at(28, SG_PLL_RST,   1);
    expect_at(28, SG_SYS_RST_N, 0);
    expect_at(28, SG_READY,     0);
    expect_at(28, SG_LCNT,      1);
    expect_at(31, SG_PLL_RST,   1);
    expect_at(32, SG_PLL_RST,   0);
    expect_at(40, SG_SYS_RST_N, 0);
    expect_at(41, SG_SYS_RST_N, 1);
    expect_at(41, SG_READY,     1);
    expect_at(41, SG_LCNT,      1);
    run_until(25);
    pll_locked = 1'b0;
    run_until(30);
    pll_locked = 1'b1;
    finish_scn(41);

    // Async reset mid-RUN: outputs and counters clear before the next edge
    run_until(45);
    apply_reset("async_run");

    // Stability glitch: drop at STABLE count 5 for 2 cycles, then relock
    expect_at(13, SG_PLL_RST,   0);
    expect_at(15, SG_SYS_RST_N, 0);
    expect_at(22, SG_SYS_RST_N, 0);
    expect_at(23, SG_SYS_RST_N, 1);
    expect_at(23, SG_READY,     1);
    expect_at(23, SG_LCNT,      0);
    expect_at(23, SG_TCNT,      0);
    run_until(4);
    pll_locked = 1'b1;
    run_until(10);
    pll_locked = 1'b0;
    run_until(12);
    pll_locked = 1'b1;
    finish_scn(23);

    // Lock arriving on the timeout cycle wins: no timeout counted
    apply_reset("pre_lockwin");
    expect_at(23, SG_PLL_RST,   0);
    expect_at(24, SG_PLL_RST,   0);
    expect_at(24, SG_TCNT,      0);
    expect_at(31, SG_SYS_RST_N, 0);
    expect_at(32, SG_SYS_RST_N, 1);
    run_until(21);
    pll_locked = 1'b1;
    finish_scn(32);

    apply_reset("pre_nolock");
`ifdef PLL_RETRY_LIMIT_EN
    // Retry limit: second timeout enters sticky FAIL
    expect_at(24,  SG_TCNT,      1);
    expect_at(24,  SG_FAIL,      0);
    expect_at(47,  SG_FAIL,      0);
    expect_at(47,  SG_PLL_RST,   0);
    expect_at(48,  SG_FAIL,      1);
    expect_at(48,  SG_PLL_RST,   1);
    expect_at(48,  SG_TCNT,      2);
    expect_at(70,  SG_FAIL,      1);
    expect_at(70,  SG_PLL_RST,   1);
    expect_at(70,  SG_SYS_RST_N, 0);
    expect_at(70,  SG_READY,     0);
    expect_at(70,  SG_TCNT,      2);
    run_until(50);
    pll_locked = 1'b1;
    finish_scn(70);
    apply_reset("fail_clear");
    expect_at(0, SG_FAIL,    0);
    expect_at(0, SG_PLL_RST, 1);
    expect_at(4, SG_PLL_RST, 0);
    finish_scn(4);
`else
    // Never lock: 24-cycle retry period, timeout counter saturates at 255
    expect_at(0,    SG_PLL_RST,   1);
    expect_at(3,    SG_PLL_RST,   1);
    expect_at(4,    SG_PLL_RST,   0);
    expect_at(23,   SG_PLL_RST,   0);
    expect_at(23,   SG_TCNT,      0);
    expect_at(24,   SG_PLL_RST,   1);
    expect_at(24,   SG_TCNT,      1);
    expect_at(27,   SG_PLL_RST,   1);
    expect_at(28,   SG_PLL_RST,   0);
    expect_at(48,   SG_TCNT,      2);
    expect_at(71,   SG_TCNT,      2);
    expect_at(72,   SG_TCNT,      3);
    expect_at(72,   SG_SYS_RST_N, 0);
    expect_at(72,   SG_READY,     0);
    expect_at(6096, SG_TCNT,      254);
    expect_at(6120, SG_TCNT,      255);
    expect_at(6144, SG_TCNT,      255);
    expect_at(6144, SG_PLL_RST,   1);
    expect_at(6144, SG_SYS_RST_N, 0);
    expect_at(6144, SG_FAIL,      0);
    finish_scn(6144);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
